// File: rtl/bit_serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side loads operands; the slave side (the subtractor) returns results and status.
interface bit_serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] A_shiftdata;
    logic [WIDTH-1:0] B_shiftdata;
    logic             busy;
    logic             done;

    modport master (
        output load, A, B,
        input  diff, borrow, A_shiftdata, B_shiftdata, busy, done
    );

    modport slave (
        input  load, A, B,
        output diff, borrow, A_shiftdata, B_shiftdata, busy, done
    );
endinterface

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: A and B are streamed LSB-first through one full-subtractor cell.
// Difference bits enter the result register at the MSB end, so after WIDTH shifts the
// result is aligned.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no operation; diff/borrow hold the last result
// LOADED | operands captured, first shift happens on the next edge
// SHIFT  | shifting, one difference bit per edge
// DONE   | final diff/borrow valid for this one cycle (done=1)
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bit_serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             shifting;
    logic             last_shift;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             borrow_next;

    assign shifting    = (state == LOADED) || (state == SHIFT);
    assign last_shift  = (count == CNT_W'(WIDTH - 1));
    assign a_bit       = a_sr[0];
    assign b_bit       = b_sr[0];
    assign d_bit       = a_bit ^ b_bit ^ borrow_q;
    assign borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a load request overrides whatever the FSM was doing.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:          state_next = IDLE;
            LOADED, SHIFT: state_next = last_shift ? DONE : SHIFT;
            DONE:          state_next = IDLE;
            default:       state_next = IDLE;
        endcase
        if (bus.load) begin
            state_next = LOADED;
        end
    end

    // Datapath: parallel load, otherwise one subtractor step per edge while shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            count    <= '0;
        end else if (bus.load) begin
            a_sr     <= bus.A;
            b_sr     <= bus.B;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            count    <= '0;
        end else if (shifting) begin
            a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
            diff_q   <= {d_bit, diff_q[WIDTH-1:1]};
            borrow_q <= borrow_next;
            count    <= count + 1'b1;
        end
    end

    assign bus.diff        = diff_q;
    assign bus.borrow      = borrow_q;
    assign bus.A_shiftdata = a_sr;
    assign bus.B_shiftdata = b_sr;
    assign bus.busy        = shifting;
    assign bus.done        = (state == DONE);
endmodule
